// File: rtl/tp_ram_pkg.sv
// Shared constants for the tp_ram read engine: FSM encoding, RAM read latency
// and output buffer depth.
package tp_ram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int RD_LATENCY = 1;
  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/tp_ram_reader_if.sv
// RAM read port plus valid/ready output stream of tp_ram_reader.
// master = the reader, slave = RAM and downstream consumer side.
interface tp_ram_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);

  logic                  ram_rden;
  logic [ADDR_WIDTH-1:0] ram_addrrd;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output ram_rden, ram_addrrd, m_data, m_valid, m_last,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_rden, ram_addrrd, m_data, m_valid, m_last,
    output ram_dout, m_ready
  );

endinterface

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO holding {last, data} words returned by the RAM.
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_skid_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           not_empty,
  output logic [$clog2(DEPTH+1)-1:0]     occ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data  = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign occ       = count;

endmodule

// File: rtl/tp_ram_reader.sv
// Burst read engine for tp_ram: issues reads, absorbs the 1-cycle RAM latency
// and streams words out with backpressure. Option: TP_RAM_READER_CHECKSUM_EN.
module tp_ram_reader
  import tp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
`ifdef TP_RAM_READER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  tp_ram_reader_if.master       bus
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   accepted;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   fifo_out;
  logic                  start_ok;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;
  logic                  last_accept;

  // Issue only while the buffer plus the word in flight still leaves room
  // after this cycle's pop; this is the only input-to-output comb path.
  always_comb begin
    start_ok    = (state == ST_IDLE) && start && (len != '0) && (len <= MAX_LEN);
    pop         = bus.m_valid && bus.m_ready;
    last_issue  = (issued == len_q - ONE);
    last_accept = (accepted == len_q - ONE);
    issue       = (state == ST_READ) && (issued != len_q) &&
                  (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  end

  assign bus.ram_rden   = issue;
  assign bus.ram_addrrd = addr;
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      issued        <= '0;
      accepted      <= '0;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && last_issue;
      if (issue) begin
        addr   <= addr + ADDR_WIDTH'(1);
        issued <= issued + ONE;
      end
      if (pop) begin
        accepted <= accepted + ONE;
      end
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            addr     <= start_addr;
            len_q    <= len;
            issued   <= '0;
            accepted <= '0;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue && last_issue) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && last_accept) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, bus.ram_dout}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .not_empty (bus.m_valid),
    .occ       (occ)
  );

  assign bus.m_last = fifo_out[DATA_WIDTH];
  assign bus.m_data = fifo_out[DATA_WIDTH-1:0];

`ifdef TP_RAM_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + bus.m_data;
    end
  end
`else
  // Without the accumulator, accepted words are only forwarded downstream.
`endif

endmodule

// File: tb/tb_tp_ram_reader.sv
// Self-checking bench for tp_ram_reader: a RAM model, a queue-based stream
// model checked every cycle, and directed plus randomized bursts.
module tb_tp_ram_reader;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
`ifdef TP_RAM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  tp_ram_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  tp_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
`ifdef TP_RAM_READER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [DEPTH];

  // RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.ram_rden) bus.ram_dout <= ram_mem[bus.ram_addrrd];
  end

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit mon_on = 0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
  endtask

  // Ready patterns: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int ready_phase = 0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.m_ready = 1'b1;
        1: begin
          bus.m_ready = ((ready_phase % 3) == 0);
          ready_phase++;
        end
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Behavioural model: words captured but not yet accepted sit in buf_q,
  // the word read last cycle sits in infl_word.
  bit            busy_m = 0;
  bit            done_m = 0;
  int            len_m = 0;
  int            issued_m = 0;
  int            accepted_m = 0;
  logic [AW-1:0] next_addr_m = '0;
  logic [DW:0]   buf_q[$];
  bit            infl_m = 0;
  logic [DW:0]   infl_word = '0;
  logic [DW-1:0] sum_m = '0;

  logic [DW-1:0] got_q[$];
  int            last_idx = -1;
  int            t_start = 0;
  int            t_first_valid = -1;
  int            t_done_dut = 0;
  int            dut_done_count = 0;

  always @(negedge clk) begin
    bit          pop_m;
    bit          exp_rden;
    logic [DW:0] w;
    if (mon_on) begin
      pop_m    = (buf_q.size() > 0) && bus.m_ready;
      exp_rden = busy_m && (issued_m < len_m) &&
                 ((buf_q.size() + int'(infl_m) - int'(pop_m)) < 2);
      check_output("busy", 32'(busy), 32'(busy_m));
      check_output("done", 32'(done), 32'(done_m));
      check_output("ram_rden", 32'(bus.ram_rden), 32'(exp_rden));
      if (exp_rden && bus.ram_rden) begin
        check_output("ram_addrrd", 32'(bus.ram_addrrd), 32'(next_addr_m));
        check_output("occ_bound", 32'((issued_m + 1 - accepted_m - int'(pop_m)) <= 2), 32'd1);
      end
      check_output("m_valid", 32'(bus.m_valid), 32'(buf_q.size() > 0));
      if (bus.m_valid && buf_q.size() > 0) begin
        check_output("m_data", 32'(bus.m_data), 32'(buf_q[0][DW-1:0]));
        check_output("m_last", 32'(bus.m_last), 32'(buf_q[0][DW]));
      end
`ifdef TP_RAM_READER_CHECKSUM_EN
      if (done_m) check_output("checksum", 32'(checksum), 32'(sum_m));
`endif
      if (done) begin
        t_done_dut = cyc;
        dut_done_count++;
      end
      if (bus.m_valid && t_first_valid < 0) t_first_valid = cyc;

      if (rst) begin
        busy_m = 0; done_m = 0; len_m = 0; issued_m = 0; accepted_m = 0;
        buf_q.delete(); infl_m = 0; sum_m = '0;
      end else begin
        done_m = 0;
        if (pop_m) begin
          w = buf_q.pop_front();
          got_q.push_back(w[DW-1:0]);
          sum_m = sum_m + w[DW-1:0];
          accepted_m++;
          if (w[DW]) begin
            last_idx = got_q.size() - 1;
            done_m   = 1;
            busy_m   = 0;
          end
        end
        if (infl_m) buf_q.push_back(infl_word);
        infl_m = exp_rden;
        if (exp_rden) begin
          infl_word   = {(issued_m == len_m - 1), ram_mem[next_addr_m]};
          next_addr_m = next_addr_m + 1'b1;
          issued_m++;
        end
        if (!busy_m && start && len != 0 && len <= DEPTH) begin
          busy_m = 1; len_m = int'(len); next_addr_m = start_addr;
          issued_m = 0; accepted_m = 0; sum_m = '0;
          t_start = cyc; t_first_valid = -1; last_idx = -1;
          got_q.delete();
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [AW-1:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    bit seen;
    c0 = dut_done_count;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (dut_done_count > c0) seen = 1;
    end
    if (!seen) check_output("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_ram(input bit identity);
    for (int i = 0; i < DEPTH; i++)
      ram_mem[i] = identity ? DW'(i) : DW'($urandom_range(0, 255));
  endtask

  initial begin
    int c0;
    int b2b_cyc;
    fill_ram(1);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_rden", 32'(bus.ram_rden), 32'd0);
    check_output("reset_valid", 32'(bus.m_valid), 32'd0);
    check_output("reset_data", 32'(bus.m_data), 32'd0);
    check_output("reset_last", 32'(bus.m_last), 32'd0);
    mon_on = 1;
    rst = 1'b0;

    $display("[TB] basic burst");
    apply_stimulus(5'd0, 6'd32);
    wait_done(200);
    check_output("basic_first_valid_cycle", 32'(t_first_valid - t_start), 32'd3);
    check_output("basic_done_cycle", 32'(t_done_dut - t_start), 32'd35);
    check_output("basic_count", 32'(got_q.size()), 32'd32);
    check_output("basic_last_idx", 32'(last_idx), 32'd31);
    if (got_q.size() == 32) begin
      check_output("basic_word0", 32'(got_q[0]), 32'd0);
      check_output("basic_word31", 32'(got_q[31]), 32'd31);
    end
`ifdef TP_RAM_READER_CHECKSUM_EN
    @(posedge clk); #1;
    check_output("checksum_literal", 32'(checksum), 32'd240);
`endif

    $display("[TB] wrap-around");
    apply_stimulus(5'd30, 6'd4);
    wait_done(100);
    check_output("wrap_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check_output("wrap_w0", 32'(got_q[0]), 32'd30);
      check_output("wrap_w1", 32'(got_q[1]), 32'd31);
      check_output("wrap_w2", 32'(got_q[2]), 32'd0);
      check_output("wrap_w3", 32'(got_q[3]), 32'd1);
    end
    check_output("wrap_last_idx", 32'(last_idx), 32'd3);

    $display("[TB] backpressure");
    fill_ram(0);
    ready_mode = 1;
    apply_stimulus(5'($urandom_range(0, 31)), 6'd8);
    wait_done(200);
    check_output("bp_count", 32'(got_q.size()), 32'd8);

    $display("[TB] random bursts");
    ready_mode = 2;
    for (int n = 0; n < 8; n++) begin
      fill_ram(0);
      apply_stimulus(5'($urandom_range(0, 31)), 6'($urandom_range(1, 32)));
      wait_done(400);
    end
    ready_mode = 0;

    $display("[TB] zero length");
    c0 = dut_done_count;
    apply_stimulus(5'd3, 6'd0);
    repeat (6) @(posedge clk);
    check_output("len0_no_done", 32'(dut_done_count), 32'(c0));

    $display("[TB] start while busy");
    c0 = dut_done_count;
    ready_mode = 2;
    apply_stimulus(5'd7, 6'd10);
    repeat (2) @(posedge clk);
    apply_stimulus(5'd20, 6'd3);
    wait_done(300);
    repeat (12) @(posedge clk);
    check_output("busy_start_one_done", 32'(dut_done_count - c0), 32'd1);
    ready_mode = 0;

    $display("[TB] back-to-back");
    c0 = dut_done_count;
    apply_stimulus(5'd12, 6'd5);
    b2b_cyc = -1;
    for (int i = 0; i < 100 && b2b_cyc < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        b2b_cyc = cyc;
        start = 1'b1; start_addr = 5'd25; len = 6'd9;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    check_output("b2b_start_cycle", 32'(t_start), 32'(b2b_cyc));
    check_output("b2b_done_count", 32'(dut_done_count - c0), 32'd2);
    check_output("b2b_count", 32'(got_q.size()), 32'd9);

    $display("[TB] reset mid-burst");
    c0 = dut_done_count;
    apply_stimulus(5'd4, 6'd16);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_rden", 32'(bus.ram_rden), 32'd0);
    check_output("midrst_valid", 32'(bus.m_valid), 32'd0);
    check_output("midrst_data", 32'(bus.m_data), 32'd0);
    check_output("midrst_last", 32'(bus.m_last), 32'd0);
    repeat (20) @(posedge clk);
    check_output("midrst_no_done", 32'(dut_done_count), 32'(c0));
    fill_ram(0);
    apply_stimulus(5'd9, 6'd11);
    wait_done(200);
    check_output("post_rst_count", 32'(got_q.size()), 32'd11);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
